// File: rtl/mem_stage_pkg.sv
// Shared CPU package: widths and the MEM
// stage FSM encoding.
package mem_stage_pkg;

  localparam int DATA_W = 10;
  localparam int REG_W  = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/mem_stage_mem_wb_reg.sv
// MEM/WB pipeline register with load
// enable and bubble insert.
module mem_wb_reg
  import mem_stage_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             bubble,
  input  logic [W-1:0]     data,
  input  logic [REG_W-1:0] sel,
  input  logic             en,
  output logic [W-1:0]     wb_data,
  output logic [REG_W-1:0] wb_sel,
  output logic             wb_en
);

  // load a new writeback, or kill only the
  // enable so the other fields hold
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      wb_data <= '0;
      wb_sel  <= '0;
      wb_en   <= 1'b0;
    end else if (load) begin
      wb_data <= data;
      wb_sel  <= sel;
      wb_en   <= en;
    end else if (bubble) begin
      wb_en   <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: req/ack memory port,
// stall generation and MEM/WB register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W  = mem_stage_pkg::DATA_W,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] ALU_result_in,
  input  logic [DATA_W-1:0] rt_in,
  input  logic [REG_W-1:0]  reg_writesel_in,
  input  logic              reg_write_en_in,
  input  logic              RAM_writeEnable_in,
  input  logic              MemtoReg_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cache_Ready,
  output logic [DATA_W-1:0] wb_data_out,
  output logic [REG_W-1:0]  reg_writesel_out,
  output logic              reg_write_en_out,
  output logic              mem_error,
  output logic [CNT_W-1:0]  stall_count
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_e state;
  state_e state_nxt;

  logic [TW-1:0]     tcnt;
  logic [DATA_W-1:0] lbuf;
  logic [DATA_W-1:0] wb_sel_data;
  logic mem_op;
  logic tmo;
  logic got_ack;
  logic abort;
  logic start;
  logic wb_load;
  logic wb_bubble;

  assign mem_op  = MemtoReg_in | RAM_writeEnable_in;
  assign tmo     = (tcnt == TW'(TIMEOUT - 1));
  assign got_ack = (state == ACCESS) & mem_ack;
  assign abort   = (state == ACCESS) & ~mem_ack & tmo;

  // state register
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state: ack beats timeout
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (mem_op) state_nxt = ACCESS;
      ACCESS:  if (mem_ack || tmo) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // stall and MEM/WB control per state
  always_comb begin
    cache_Ready = 1'b1;
    wb_load     = 1'b0;
    wb_bubble   = 1'b0;
    start       = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem_op) begin
          cache_Ready = 1'b0;
          wb_bubble   = 1'b1;
          start       = 1'b1;
        end else begin
          wb_load = 1'b1;
        end
      end
      ACCESS: begin
        cache_Ready = 1'b0;
        wb_bubble   = 1'b1;
      end
      DONE:    wb_load = 1'b1;
      default: ;
    endcase
  end

  // only a pure load returns memory data
  assign wb_sel_data =
    (state == DONE && MemtoReg_in &&
     !RAM_writeEnable_in) ? lbuf : ALU_result_in;

  // memory port: launch once, hold until
  // ack or abort
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (start) begin
      mem_req   <= 1'b1;
      mem_we    <= RAM_writeEnable_in;
      mem_addr  <= ALU_result_in;
      mem_wdata <= rt_in;
    end else if (got_ack || abort) begin
      mem_req   <= 1'b0;
    end
  end

  // cycles spent waiting for the ack
  always_ff @(negedge clk or negedge reset) begin
    if (!reset)               tcnt <= '0;
    else if (start)           tcnt <= '0;
    else if (state == ACCESS) tcnt <= tcnt + TW'(1);
  end

  // load buffer; an aborted access reads 0
  always_ff @(negedge clk or negedge reset) begin
    if (!reset)                  lbuf <= '0;
    else if (got_ack && !mem_we) lbuf <= mem_rdata;
    else if (abort)              lbuf <= '0;
  end

  // sticky timeout flag
  always_ff @(negedge clk or negedge reset) begin
    if (!reset)     mem_error <= 1'b0;
    else if (abort) mem_error <= 1'b1;
  end

  // saturating stall-cycle counter
  always_ff @(negedge clk or negedge reset) begin
    if (!reset)
      stall_count <= '0;
    else if (!cache_Ready && stall_count != '1)
      stall_count <= stall_count + CNT_W'(1);
  end

  mem_wb_reg #(.W(DATA_W)) u_mem_wb (
    .clk     (clk),
    .reset   (reset),
    .load    (wb_load),
    .bubble  (wb_bubble),
    .data    (wb_sel_data),
    .sel     (reg_writesel_in),
    .en      (reg_write_en_in),
    .wb_data (wb_data_out),
    .wb_sel  (reg_writesel_out),
    .wb_en   (reg_write_en_out)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed
// ops, memory model, commit/request monitor.
module tb_mem_stage;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] ALU_result_in;
  logic [9:0] rt_in;
  logic [2:0] reg_writesel_in;
  logic       reg_write_en_in;
  logic       RAM_writeEnable_in;
  logic       MemtoReg_in;
  logic       mem_req;
  logic       mem_we;
  logic [9:0] mem_addr;
  logic [9:0] mem_wdata;
  logic       mem_ack;
  logic [9:0] mem_rdata;
  logic       cache_Ready;
  logic [9:0] wb_data_out;
  logic [2:0] reg_writesel_out;
  logic       reg_write_en_out;
  logic       mem_error;
  logic [15:0] stall_count;

  mem_stage #(
    .DATA_W(10), .TIMEOUT(15), .CNT_W(16)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .ALU_result_in      (ALU_result_in),
    .rt_in              (rt_in),
    .reg_writesel_in    (reg_writesel_in),
    .reg_write_en_in    (reg_write_en_in),
    .RAM_writeEnable_in (RAM_writeEnable_in),
    .MemtoReg_in        (MemtoReg_in),
    .mem_req            (mem_req),
    .mem_we             (mem_we),
    .mem_addr           (mem_addr),
    .mem_wdata          (mem_wdata),
    .mem_ack            (mem_ack),
    .mem_rdata          (mem_rdata),
    .cache_Ready        (cache_Ready),
    .wb_data_out        (wb_data_out),
    .reg_writesel_out   (reg_writesel_out),
    .reg_write_en_out   (reg_write_en_out),
    .mem_error          (mem_error),
    .stall_count        (stall_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [13:0] wb_q[$];
  logic [20:0] req_q[$];

  logic tb_valid = 1'b0;
  logic late_ack = 1'b0;
  int   ack_delay = -1;
  int   last_req_width = 0;
  int   req_gap = 0;
  int   pulses = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  // memory: acks ack_delay cycles after the
  // first cycle mem_req is seen high
  initial begin
    int cnt;
    logic [9:0] ram [1024];
    cnt = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    foreach (ram[i]) ram[i] = '0;
    ram[10'h020] = 10'h155;
    forever begin
      @(posedge clk); #1;
      if (mem_ack) begin
        mem_ack = 1'b0;
        cnt = 0;
      end else if (late_ack) begin
        mem_ack = 1'b1;
      end else if (mem_req && ack_delay >= 0) begin
        cnt++;
        if (cnt == ack_delay + 1) begin
          mem_ack = 1'b1;
          if (mem_we) ram[mem_addr] = mem_wdata;
          else        mem_rdata = ram[mem_addr];
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // monitor: MEM/WB commits and req pulses
  initial begin
    logic rdy_prev;
    logic req_prev;
    int   width;
    int   low_run;
    logic [13:0] e;
    logic [20:0] r;
    rdy_prev = 1'b0;
    req_prev = 1'b0;
    width = 0;
    low_run = 0;
    forever begin
      @(posedge clk); #3;
      if (rdy_prev) begin
        if (wb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wb_unexpected actual=%0h",
            {wb_data_out, reg_writesel_out,
             reg_write_en_out});
        end else begin
          e = wb_q.pop_front();
          check("wb_commit",
            {wb_data_out, reg_writesel_out,
             reg_write_en_out}, e);
        end
      end
      if (mem_req && !req_prev) begin
        pulses++;
        req_gap = low_run;
        width = 0;
        if (req_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL req_unexpected addr=%0h",
                   mem_addr);
        end else begin
          r = req_q.pop_front();
          check("req_fields",
                {mem_we, mem_addr, mem_wdata}, r);
        end
      end
      if (mem_req) width++;
      if (!mem_req && req_prev) last_req_width = width;
      low_run = mem_req ? 0 : low_run + 1;
      req_prev = mem_req;
      rdy_prev = cache_Ready & tb_valid & reset;
    end
  end

  task automatic issue(input logic [9:0] alu,
                       input logic [9:0] rt,
                       input logic [2:0] sel,
                       input logic wen,
                       input logic we,
                       input logic mtr,
                       input logic [9:0] exp_wb);
    int n;
    n = 0;
    @(posedge clk); #1;
    ALU_result_in = alu;
    rt_in = rt;
    reg_writesel_in = sel;
    reg_write_en_in = wen;
    RAM_writeEnable_in = we;
    MemtoReg_in = mtr;
    tb_valid = 1'b1;
    wb_q.push_back({exp_wb, sel, wen});
    if (we | mtr) req_q.push_back({we, alu, rt});
    #1;
    while (!cache_Ready && n < 60) begin
      @(posedge clk); #2;
      n++;
    end
    if (!cache_Ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=0 required=1");
    end
  endtask

  task automatic drive_nop();
    ALU_result_in = '0;
    rt_in = '0;
    reg_writesel_in = '0;
    reg_write_en_in = 1'b0;
    RAM_writeEnable_in = 1'b0;
    MemtoReg_in = 1'b0;
    tb_valid = 1'b0;
  endtask

  task automatic nop();
    @(posedge clk); #1;
    drive_nop();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    drive_nop();
    #3 reset = 1'b0;
    #1;
    check("rst_port",
          {mem_req, mem_we, mem_addr, mem_wdata}, 0);
    check("rst_wb",
          {wb_data_out, reg_writesel_out,
           reg_write_en_out}, 0);
    check("rst_err_stall", {mem_error, stall_count}, 0);
    check("rst_ready", cache_Ready, 1);
    @(posedge clk); #2 reset = 1'b1;

    issue(10'h003, 10'h000, 3'b010, 1, 0, 0, 10'h003);
    nop();

    ack_delay = 3;
    issue(10'h020, 10'h000, 3'b100, 1, 0, 1, 10'h155);
    nop();
    check("load_stall", stall_count, 5);
    check("load_req_width", last_req_width, 4);

    ack_delay = 1;
    issue(10'h010, 10'h2AA, 3'b001, 0, 1, 0, 10'h010);
    issue(10'h010, 10'h000, 3'b011, 1, 0, 1, 10'h2AA);
    nop();
    // low for the store's DONE, then one IDLE
    check("b2b_gap", req_gap, 2);
    check("b2b_pulses", pulses, 3);
    check("b2b_stall", stall_count, 11);

    issue(10'h030, 10'h0F0, 3'b110, 1, 1, 1, 10'h030);
    nop();
    check("both_stall", stall_count, 14);

    ack_delay = -1;
    issue(10'h040, 10'h000, 3'b101, 1, 0, 1, 10'h000);
    nop();
    check("tmo_width", last_req_width, 15);
    check("tmo_error", mem_error, 1);
    check("tmo_stall", stall_count, 30);
    issue(10'h1FF, 10'h000, 3'b111, 1, 0, 0, 10'h1FF);
    nop();
    check("error_sticky", mem_error, 1);

    @(posedge clk); #1;
    ALU_result_in = 10'h050;
    reg_writesel_in = 3'b010;
    reg_write_en_in = 1'b1;
    MemtoReg_in = 1'b1;
    tb_valid = 1'b1;
    req_q.push_back({1'b0, 10'h050, 10'h000});
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    drive_nop();
    #1;
    check("midrst_req", mem_req, 0);
    check("midrst_port",
          {mem_we, mem_addr, mem_wdata}, 0);
    check("midrst_ready", cache_Ready, 1);
    check("midrst_err_stall",
          {mem_error, stall_count}, 0);
    check("midrst_wb",
          {wb_data_out, reg_writesel_out,
           reg_write_en_out}, 0);
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #2 late_ack = 1'b1;
    @(posedge clk); #2 late_ack = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("late_ack_req", mem_req, 0);
    check("late_ack_stall", stall_count, 0);
    issue(10'h07C, 10'h000, 3'b110, 1, 0, 0, 10'h07C);
    nop();
    repeat (2) @(posedge clk);
    #4;
    check("wb_q_drained", wb_q.size(), 0);
    check("req_q_drained", req_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 10-bit pipeline, directly downstream of the EX/MEM pipeline register.
- Consumes the registered ALU result, store data and memory/writeback controls, and runs load/store transactions on an external RAM/cache port with a req/ack handshake.
- Drives cache_Ready back to the EX/MEM register and upstream stages as the stall signal.
- Registers the writeback data and controls into the MEM/WB boundary.

Parameters:
- DATA_W, 10, data and address width.
- TIMEOUT, 15, maximum cycles mem_req stays high without mem_ack before the access is aborted.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  pipeline clock; all flops update on the falling edge, matching the pipeline registers.
- reset  in  1  asynchronous, active-low; reset==0 forces the reset state immediately.
- ALU_result_in  in  DATA_W  address for memory ops, writeback value for ALU ops.
- rt_in  in  DATA_W  store data.
- reg_writesel_in  in  3  destination register index.
- reg_write_en_in  in  1  writeback enable.
- RAM_writeEnable_in  in  1  store request.
- MemtoReg_in  in  1  load request.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
- mem_addr  out  DATA_W  registered address.
- mem_wdata  out  DATA_W  registered store data.
- mem_ack  in  1  one-cycle acknowledge from memory.
- mem_rdata  in  DATA_W  read data; valid when mem_ack=1.
- cache_Ready  out  1  combinational; 0 stalls EX/MEM and upstream stages.
- wb_data_out  out  DATA_W  MEM/WB writeback value.
- reg_writesel_out  out  3  MEM/WB destination.
- reg_write_en_out  out  1  MEM/WB writeback enable.
- mem_error  out  1  sticky timeout flag.
- stall_count  out  CNT_W  saturating count of cycles with cache_Ready=0.

Behaviour:
- Memory op: mem_op = MemtoReg_in | RAM_writeEnable_in. If both are set, treat the op as a store; reg_write_en is still honoured, with wb_data = ALU_result_in.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, mem_op=0:
  - cache_Ready=1.
  - MEM/WB loads wb_data_out = ALU_result_in, plus writesel and write_en, every edge.
  - Zero added latency.
- IDLE, mem_op=1:
  - cache_Ready=0; MEM/WB loads a bubble (reg_write_en_out=0, other MEM/WB fields hold).
  - At the edge, mem_req<=1, mem_we<=RAM_writeEnable_in, mem_addr<=ALU_result_in, mem_wdata<=rt_in.
  - Timeout counter cleared; go to ACCESS.
- ACCESS:
  - cache_Ready=0; mem_req, mem_addr, mem_wdata and mem_we held stable; counter increments each edge.
  - mem_ack=1: mem_req<=0; capture mem_rdata into the load buffer for reads; go to DONE.
  - Counter reaches TIMEOUT with no ack: mem_req<=0, load buffer<=0, mem_error<=1; go to DONE.
  - mem_ack and timeout in the same cycle: ack wins, no error.
- DONE:
  - cache_Ready=1.
  - MEM/WB loads wb_data_out = load buffer if MemtoReg_in&~RAM_writeEnable_in, else ALU_result_in, plus writesel and write_en.
  - Go to IDLE. EX/MEM advances on the same edge.
- Each memory op has a single request.
  - Load/store latency through the stage = ack latency + 2 cycles.
  - Back-to-back memory ops re-enter ACCESS via IDLE, with one IDLE cycle between requests.
- mem_ack while not in ACCESS: ignored.
- Inputs are stable while cache_Ready=0, because EX/MEM holds its contents.
- stall_count increments on each edge where cache_Ready=0 and saturates at all-ones.
- mem_error is cleared only by reset.
- Reset, including mid-access: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, load buffer=0, wb_data_out=0, reg_writesel_out=0, reg_write_en_out=0, mem_error=0, stall_count=0, timeout counter=0. No pending transaction survives reset.

Decomposition:
- Shared CPU package holds:
  - DATA_W=10.
  - Register-index width 3.
  - FSM state encoding: IDLE=2'd0, ACCESS=2'd1, DONE=2'd2.
- One natural sub-module: mem_wb_reg, the MEM/WB pipeline register with load-enable and bubble insert.
- The FSM, timeout counter and stall counter stay in mem_stage.

Test Plan:
- Reset: hold reset=0 mid-clock, then release.
  - Every output is 0 immediately; cache_Ready=1 when inputs are a non-mem op.
- ALU op: ALU_result_in=10'h003, writesel=3'b010, write_en=1.
  - Next falling edge: wb_data_out=10'h003, reg_writesel_out=2, reg_write_en_out=1; mem_req never rises.
- Load: MemtoReg_in=1, ALU_result_in=10'h020, writesel=3'b100; memory acks 3 cycles after mem_req with rdata=10'h155.
  - mem_req=1 with addr=10'h020, we=0; cache_Ready=0 for 5 cycles.
  - Then wb_data_out=10'h155, reg_write_en_out=1; stall_count=5.
- Store then load back-to-back: store addr 10'h010, data 10'h2AA, ack after 1 cycle; then load the same address.
  - Two distinct mem_req pulses with one IDLE cycle between them.
  - Store bubble keeps reg_write_en_out=0; load writes back the acked data.
- Timeout: load with mem_ack never asserted.
  - mem_req drops after TIMEOUT=15 cycles; mem_error=1 and stays set.
  - wb_data_out=0; the pipeline resumes with cache_Ready=1 in DONE.
- Reset mid-access: assert reset=0 while in ACCESS.
  - mem_req=0 and state IDLE immediately; a late mem_ack after release is ignored.
  - The next ALU op passes through normally.
